// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
// State encoding and default operand width.
package serial_arith_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the serial subtractor.
// master = controller side, slave = arithmetic unit side.
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int N = DEF_WIDTH
) ();

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;

    modport master (
        output start, A, B,
        input  D, Bout, busy, done
    );

    modport slave (
        input  start, A, B,
        output D, Bout, busy, done
    );

endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full-subtractor cell: d = a - b - bin.
module fullSubtractor1b (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock.
// A single full-subtractor cell plus a borrow flop ripples over N cycles.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    serial_subtractor_if.slave bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        nxt;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  sd;
    logic [N-1:0]  d_q;
    logic          bout_q;
    logic          br;
    logic [CW-1:0] cnt;
    logic          cell_d;
    logic          cell_b;
    logic          accept;
    logic          run;
    logic          last;
    logic          busy_c;
    logic          done_c;

    assign run    = (state == ST_RUN);
    assign last   = run && (cnt == LAST);
    assign accept = bus.start && (state != ST_RUN);

    fullSubtractor1b u_cell (
        .A    (sa[0]),
        .B    (sb[0]),
        .Bin  (br),
        .D    (cell_d),
        .Bout (cell_b)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cnt == LAST) nxt = ST_DONE;
            end
            ST_DONE: begin
                nxt = bus.start ? ST_RUN : ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        unique case (state)
            ST_RUN:  busy_c = 1'b1;
            ST_DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    // sd collects bits from the MSB side; it is fully rewritten every op
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            sa  <= bus.A;
            sb  <= bus.B;
            br  <= 1'b0;
            cnt <= '0;
        end else if (run) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= {cell_d, sd[N-1:1]};
            br  <= cell_b;
            cnt <= cnt + CW'(1);
            if (last) begin
                d_q    <= {cell_d, sd[N-1:1]};
                bout_q <= cell_b;
            end
        end
    end

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.busy = busy_c;
    assign bus.done = done_c;

endmodule
